// File: rtl/cve2_pkg.sv
// Shared CSR numbers, operation codes and HPM event indices for the CVE2 counter bank.
package cve2_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83
    } csr_num_e;

    typedef enum logic [3:0] {
        HPM_EVT_STALL_LOAD   = 4'd0,
        HPM_EVT_STALL_FETCH  = 4'd1,
        HPM_EVT_LOAD         = 4'd2,
        HPM_EVT_STORE        = 4'd3,
        HPM_EVT_JUMP         = 4'd4,
        HPM_EVT_BRANCH       = 4'd5,
        HPM_EVT_BRANCH_TAKEN = 4'd6,
        HPM_EVT_COMPRESSED   = 4'd7,
        HPM_EVT_DIV_WAIT     = 4'd8,
        HPM_EVT_MUL_WAIT     = 4'd9
    } hpm_event_e;

    localparam logic [11:0] CSR_OFF_MHPMCOUNTER  = 12'hB00;
    localparam logic [11:0] CSR_OFF_MHPMCOUNTERH = 12'hB80;
    localparam logic [11:0] CSR_OFF_MHPMEVENT    = 12'h320;

endpackage

// File: rtl/cve2_counter.sv
// One machine counter of configurable width; written per 32-bit half, read zero-extended to 64 bits.
module cve2_counter #(
    parameter int unsigned Width = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        incr_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o,
    output logic        ovf_o
);
    logic [Width-1:0] cnt_q, cnt_d;
    logic [63:0]      ext_q, ext_d;
    logic             unused_ext;

    assign ext_q = 64'(cnt_q);

    // A write to either half wins over the increment in the same cycle.
    always_comb begin
        ext_d = ext_q;
        if (we_lo_i) begin
            ext_d[31:0] = wdata_i;
        end else if (we_hi_i) begin
            ext_d[63:32] = wdata_i;
        end else if (incr_i) begin
            ext_d = ext_q + 64'd1;
        end
        cnt_d = ext_d[Width-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign unused_ext = ^ext_d;
    assign value_o    = ext_q;
    assign ovf_o      = incr_i & ~we_lo_i & ~we_hi_i & (&cnt_q);
endmodule

// File: rtl/cve2_counter_bank.sv
// Machine counter bank: mcycle, minstret, mhpmcounterN/mhpmeventN and mcountinhibit.
// CVE2_HPM_OVF_IRQ_EN adds sticky per-counter overflow flags driving irq_ovf_o.
module cve2_counter_bank import cve2_pkg::*; #(
    parameter int unsigned MHPMCounterNum   = 10,
    parameter int unsigned MHPMCounterWidth = 40,
    parameter int unsigned NumEvents        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 csr_access_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [1:0]           csr_op_i,
    input  logic                 csr_op_en_i,
    input  logic [31:0]          csr_wdata_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_hit_o,
    input  logic                 instr_ret_i,
    input  logic [NumEvents-1:0] event_i,
    output logic                 irq_ovf_o
);
    localparam logic [63:0] HpmBits = ((64'd1 << MHPMCounterNum) - 64'd1) << 3;
    localparam logic [31:0] InhMask = 32'h5 | HpmBits[31:0];

    csr_op_e    op;
    logic [4:0] idx;
    logic       hi_sel, cnt_sel, evt_sel, inh_sel, we;
    logic [31:0] rdata, wval, inh_q;
    logic [31:0][63:0]          cnt_val;
    logic [31:0][NumEvents-1:0] evt_val;
    logic [31:0]                ovf;
    logic                       unused_ovf;
`ifdef CVE2_HPM_OVF_IRQ_EN
    logic [31:0]                flag_val;
`endif

    assign op      = csr_op_e'(csr_op_i);
    assign idx     = csr_addr_i[4:0];
    assign hi_sel  = csr_addr_i[7];
    // 0xB00-0xB1F and 0xB80-0xB9F, skipping the unowned slot 1 (time).
    assign cnt_sel = (csr_addr_i[11:8] == CSR_OFF_MHPMCOUNTER[11:8]) &&
                     (csr_addr_i[6:5] == 2'b00) && (idx != 5'd1);
    assign evt_sel = (csr_addr_i[11:5] == CSR_OFF_MHPMEVENT[11:5]) && (idx >= 5'd3);
    assign inh_sel = (csr_addr_i == CSR_MCOUNTINHIBIT);
    assign csr_hit_o = cnt_sel | evt_sel | inh_sel;
    assign we      = csr_access_i & csr_op_en_i & (op != CSR_OP_READ);

    always_comb begin
        rdata = '0;
        if (cnt_sel) begin
            rdata = hi_sel ? cnt_val[idx][63:32] : cnt_val[idx][31:0];
        end else if (evt_sel) begin
            rdata = 32'(evt_val[idx]);
`ifdef CVE2_HPM_OVF_IRQ_EN
            rdata[31] = flag_val[idx];
`endif
        end else if (inh_sel) begin
            rdata = inh_q;
        end
    end
    assign csr_rdata_o = rdata;

    always_comb begin
        unique case (op)
            CSR_OP_SET:   wval = rdata | csr_wdata_i;
            CSR_OP_CLEAR: wval = rdata & ~csr_wdata_i;
            default:      wval = csr_wdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)              inh_q <= '0;
        else if (we && inh_sel) inh_q <= wval & InhMask;
    end

    for (genvar i = 0; i < 32; i++) begin : g_slot
        localparam bit IsHpm = (i >= 3) && (i < 3 + MHPMCounterNum);
        if (i == 0 || i == 2 || IsHpm) begin : g_impl
            logic incr, we_lo, we_hi;
            assign we_lo = we & cnt_sel & ~hi_sel & (idx == 5'(i));
            assign we_hi = we & cnt_sel &  hi_sel & (idx == 5'(i));

            if (IsHpm) begin : g_hpm
                logic [NumEvents-1:0] evt_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i)                                 evt_q <= '0;
                    else if (we && evt_sel && idx == 5'(i))    evt_q <= wval[NumEvents-1:0];
                end
                assign evt_val[i] = evt_q;
                assign incr = ~inh_q[i] & (|(event_i & evt_q));
`ifdef CVE2_HPM_OVF_IRQ_EN
                logic flag_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i)       flag_q <= 1'b0;
                    else if (we_hi)  flag_q <= 1'b0;
                    else if (ovf[i]) flag_q <= 1'b1;
                end
                assign flag_val[i] = flag_q;
`endif
            end else begin : g_fixed
                assign evt_val[i] = '0;
                assign incr = ~inh_q[i] & ((i == 0) ? 1'b1 : instr_ret_i);
`ifdef CVE2_HPM_OVF_IRQ_EN
                assign flag_val[i] = 1'b0;
`endif
            end

            cve2_counter #(
                .Width((i < 3) ? 64 : MHPMCounterWidth)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .incr_i  (incr),
                .we_lo_i (we_lo),
                .we_hi_i (we_hi),
                .wdata_i (wval),
                .value_o (cnt_val[i]),
                .ovf_o   (ovf[i])
            );
        end else begin : g_none
            assign cnt_val[i] = '0;
            assign evt_val[i] = '0;
            assign ovf[i]     = 1'b0;
`ifdef CVE2_HPM_OVF_IRQ_EN
            assign flag_val[i] = 1'b0;
`endif
        end
    end

    assign unused_ovf = ^ovf;
`ifdef CVE2_HPM_OVF_IRQ_EN
    assign irq_ovf_o = |flag_val;
`else
    assign irq_ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_cve2_counter_bank.sv
// Bench for cve2_counter_bank: per-cycle comparison against a CSR-level model plus directed literal checks.
module tb_cve2_counter_bank;
    localparam int N = 10, W = 40, E = 16;
`ifdef CVE2_HPM_OVF_IRQ_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b1, acc = 1'b0, en = 1'b0, iret = 1'b0;
    logic [11:0]   addr = 12'h0;
    logic [1:0]    op = 2'd0;
    logic [31:0]   wd = 32'h0;
    logic [E-1:0]  ev = '0;
    logic [31:0]   rdata;
    logic          hit, irq;

    always #5 clk = ~clk;

    cve2_counter_bank #(.MHPMCounterNum(N), .MHPMCounterWidth(W), .NumEvents(E)) dut (
        .clk_i(clk), .rst_i(rst), .csr_access_i(acc), .csr_addr_i(addr), .csr_op_i(op),
        .csr_op_en_i(en), .csr_wdata_i(wd), .csr_rdata_o(rdata), .csr_hit_o(hit),
        .instr_ret_i(iret), .event_i(ev), .irq_ovf_o(irq)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: counters as plain integers indexed by CSR slot ----------------
    logic [63:0] m_cnt [32];
    logic [31:0] m_ev  [32];
    logic [31:0] old_ev[32];
    logic [31:0] m_inh, m_flag, old_inh;
    bit          started = 1'b0;

    function automatic bit impl(input int n);
        return n == 0 || n == 2 || (n >= 3 && n < 3 + N);
    endfunction

    function automatic logic [63:0] cmask(input int n);
        return (n < 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << W) - 64'd1);
    endfunction

    function automatic logic [31:0] inhmask();
        logic [31:0] m = '0;
        for (int n = 0; n < 32; n++) if (impl(n)) m[n] = 1'b1;
        return m;
    endfunction

    // kind: 0 not owned, 1 counter, 2 mhpmevent, 3 mcountinhibit
    function automatic int kind_of(input logic [11:0] a, output int n, output bit hi);
        n = 0; hi = 1'b0;
        if (a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) begin n = int'(a) - 'hB00; return 1; end
        if (a >= 12'hB80 && a <= 12'hB9F && a != 12'hB81) begin n = int'(a) - 'hB80; hi = 1'b1; return 1; end
        if (a == 12'h320) return 3;
        if (a >= 12'h323 && a <= 12'h33F) begin n = int'(a) - 'h320; return 2; end
        return 0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        int n; bit hi; int k;
        k = kind_of(a, n, hi);
        case (k)
            1: return !impl(n) ? 32'h0 : (hi ? m_cnt[n][63:32] : m_cnt[n][31:0]);
            2: return !impl(n) ? 32'h0 : (m_ev[n] | ((OvfEn && m_flag[n]) ? 32'h8000_0000 : 32'h0));
            3: return m_inh;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            for (int n = 0; n < 32; n++) begin m_cnt[n] = '0; m_ev[n] = '0; end
            m_inh = '0; m_flag = '0;
        end else begin
            int wn, n, k; bit hi; logic [31:0] nv;
            wn = -1;
            old_inh = m_inh;
            old_ev  = m_ev;
            k = kind_of(addr, n, hi);
            if (acc && en && op != 2'd0 && k != 0) begin
                nv = (op == 2'd1) ? wd : (op == 2'd2) ? (model_rd(addr) | wd) : (model_rd(addr) & ~wd);
                if (k == 1 && impl(n)) begin
                    wn = n;
                    if (hi) begin m_cnt[n] = {nv, m_cnt[n][31:0]} & cmask(n); m_flag[n] = 1'b0; end
                    else         m_cnt[n] = {m_cnt[n][63:32], nv} & cmask(n);
                end else if (k == 2 && impl(n)) begin
                    m_ev[n] = nv & 32'((64'd1 << E) - 64'd1);
                end else if (k == 3) begin
                    m_inh = nv & inhmask();
                end
            end
            for (int c = 0; c < 32; c++) begin
                bit fire;
                fire = (c == 0) ? 1'b1 : (c == 2) ? iret : (|(ev & old_ev[c][E-1:0]));
                if (impl(c) && c != wn && !old_inh[c] && fire) begin
                    if (c >= 3 && m_cnt[c] == cmask(c)) m_flag[c] = 1'b1;
                    m_cnt[c] = (m_cnt[c] + 64'd1) & cmask(c);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int n; bit hi;
            chk("rdata_vs_model", rdata, model_rd(addr));
            chk("hit_vs_model", {31'b0, hit}, {31'b0, kind_of(addr, n, hi) != 0});
            chk("irq_vs_model", {31'b0, irq}, {31'b0, OvfEn && (m_flag != 0)});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
        addr = a; op = o; wd = d; acc = 1'b1; en = 1'b1;
        tick();
        acc = 1'b0; en = 1'b0; op = 2'd0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        addr = a; #1;
        chk(nm, rdata, exp);
    endtask

    task automatic hit_chk(input logic [11:0] a, input logic exp, input string nm);
        addr = a; #1;
        chk(nm, {31'b0, hit}, {31'b0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rd(12'hB00, 32'd100, "mcycle_after_100");
        rd(12'hB02, 32'd0, "minstret_idle");
        rd(12'hB03, 32'd0, "hpm3_idle");
        hit_chk(12'hB03, 1'b1, "hit_B03");
        hit_chk(12'h7C0, 1'b0, "hit_7C0");
        hit_chk(12'hB01, 1'b0, "hit_B01");
        hit_chk(12'h33F, 1'b1, "hit_33F");
        tick();

        csr_wr(12'hB00, 2'd1, 32'hFFFF_FFFF);
        csr_wr(12'hB80, 2'd1, 32'h0);
        tick();
        rd(12'hB80, 32'd1, "mcycleh_carry");
        rd(12'hB00, 32'd0, "mcycle_carry");

        iret = 1'b1; repeat (3) tick(); iret = 1'b0;
        rd(12'hB02, 32'd3, "minstret_3");

        csr_wr(12'h323, 2'd1, 32'h5);
        ev = 16'h5; repeat (4) tick(); ev = '0;
        rd(12'hB03, 32'd4, "hpm3_four");
        csr_wr(12'h320, 2'd2, 32'h8);
        rd(12'h320, 32'h8, "inhibit_set");
        ev = 16'h5; repeat (4) tick(); ev = '0;
        rd(12'hB03, 32'd4, "hpm3_inhibited");
        csr_wr(12'h320, 2'd3, 32'h8);

        ev = 16'h5;
        csr_wr(12'hB03, 2'd1, 32'h10);
        ev = '0;
        rd(12'hB03, 32'h10, "hpm3_write_wins");
        csr_wr(12'hB1F, 2'd1, 32'h1234);
        rd(12'hB1F, 32'h0, "hpm31_unimpl");

        csr_wr(12'hB83, 2'd1, 32'hFFFF_FFFF);
        rd(12'hB83, 32'hFF, "hpm3h_trunc");
        csr_wr(12'hB03, 2'd1, 32'hFFFF_FFFF);
        ev = 16'h1; tick(); ev = '0;
        rd(12'hB03, 32'h0, "hpm3_wrap_lo");
        rd(12'hB83, 32'h0, "hpm3_wrap_hi");
        chk("irq_after_wrap", {31'b0, irq}, {31'b0, OvfEn});
        rd(12'h323, OvfEn ? 32'h8000_0005 : 32'h5, "evt3_flag");
        tick();
        chk("irq_sticky", {31'b0, irq}, {31'b0, OvfEn});
        csr_wr(12'hB83, 2'd1, 32'h0);
        chk("irq_cleared", {31'b0, irq}, 32'h0);

        repeat (5) tick();
        addr = 12'hB00; op = 2'd1; wd = 32'h55; acc = 1'b1; en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; acc = 1'b0; en = 1'b0; op = 2'd0;
        rd(12'hB00, 32'h0, "rst_mcycle");
        rd(12'hB80, 32'h0, "rst_mcycleh");
        rd(12'hB03, 32'h0, "rst_hpm3");
        rd(12'h323, 32'h0, "rst_evt3");
        rd(12'h320, 32'h0, "rst_inhibit");
        chk("rst_irq", {31'b0, irq}, 32'h0);
        repeat (3) tick();
        rd(12'hB00, 32'd3, "mcycle_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
